contador_triangular: RTL and testbench

CONTADOR_TRIANGULAR -- requirements
Module: contador_triangular

---
 rtl/contador_triangular.sv | 120 ++++++++++++
 tb/tb_contador_triangular.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/contador_triangular.sv
// Triangle / sawtooth / single-sweep counter with a 0..MAX range.
// Define CONTADOR_TRIANGULAR_CICLOS_EN to add the saturating period counter.
module contador_triangular #(
    parameter int N   = 4,
    parameter int MAX = 7
) (
    input  logic         clock,
    input  logic         zera_s_n,
    input  logic         conta,
    input  logic [1:0]   modo,
    input  logic         inicia,
    output logic [N-1:0] value,
    output logic         dir,
    output logic         meio,
    output logic         fim,
`ifdef CONTADOR_TRIANGULAR_CICLOS_EN
    output logic [7:0]   ciclos,
`endif
    output logic         ativo
);

    typedef enum logic [1:0] {
        M_TRI   = 2'b00,
        M_UP    = 2'b01,
        M_DOWN  = 2'b10,
        M_SWEEP = 2'b11
    } mode_t;

    localparam logic [N-1:0] TOP  = N'(MAX);
    localparam logic [N-1:0] ZERO = '0;
    localparam logic [N-1:0] ONE  = N'(1);

    mode_t        mode_q, mode_d;
    logic [N-1:0] value_q, value_d;
    logic         dir_q, dir_d;
    logic         meio_q, meio_d;
    logic         fim_q, fim_d;
    logic         ativo_q, ativo_d;
    logic         up;

    always_comb begin
        mode_d  = mode_q;
        value_d = value_q;
        dir_d   = dir_q;
        ativo_d = ativo_q;
        meio_d  = 1'b0;
        fim_d   = 1'b0;
        up      = 1'b0;
        if (!zera_s_n) begin
            mode_d  = mode_t'(modo);
            value_d = ZERO;
            dir_d   = 1'b1;
            ativo_d = (modo != 2'b11);
        end else if (conta) begin
            if (mode_q == M_SWEEP && !ativo_q) begin
                ativo_d = inicia;
            end else begin
                case (mode_q)
                    M_UP: begin
                        value_d = (value_q >= TOP) ? ZERO : value_q + ONE;
                        dir_d   = 1'b1;
                    end
                    M_DOWN: begin
                        value_d = (value_q == ZERO) ? TOP : value_q - ONE;
                        dir_d   = 1'b0;
                    end
                    default: begin
                        // Turn around at the ends even if dir was left
                        // stale by a previous sawtooth-down period.
                        up = (value_q == ZERO) ||
                             (dir_q && value_q != TOP);
                        value_d = up ? value_q + ONE : value_q - ONE;
                        dir_d   = up ? (value_d != TOP) : (value_d == ZERO);
                    end
                endcase
                meio_d = (value_d == TOP);
                fim_d  = (value_d == ZERO);
                if (fim_d) begin
                    mode_d  = mode_t'(modo);
                    ativo_d = (modo != 2'b11);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        mode_q  <= mode_d;
        value_q <= value_d;
        dir_q   <= dir_d;
        meio_q  <= meio_d;
        fim_q   <= fim_d;
        ativo_q <= ativo_d;
    end

`ifdef CONTADOR_TRIANGULAR_CICLOS_EN
    logic [7:0] ciclos_q, ciclos_d;

    always_comb begin
        ciclos_d = ciclos_q;
        if (!zera_s_n) begin
            ciclos_d = 8'd0;
        end else if (fim_d && ciclos_q != 8'hFF) begin
            ciclos_d = ciclos_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        ciclos_q <= ciclos_d;
    end

    assign ciclos = ciclos_q;
`endif

    assign value = value_q;
    assign dir   = dir_q;
    assign meio  = meio_q;
    assign fim   = fim_q;
    assign ativo = ativo_q;

endmodule

// File: tb/tb_contador_triangular.sv
// Random + directed bench for contador_triangular against a phase-based model.
module tb_contador_triangular;

    localparam int N   = 4;
    localparam int MAX = 7;

    logic         clock = 1'b0;
    logic         zera_s_n = 1'b0;
    logic         conta = 1'b0;
    logic [1:0]   modo = 2'b00;
    logic         inicia = 1'b0;
    logic [N-1:0] value;
    logic         dir, meio, fim, ativo;
`ifdef CONTADOR_TRIANGULAR_CICLOS_EN
    logic [7:0]   ciclos;
`endif

    contador_triangular #(.N(N), .MAX(MAX)) dut (
        .clock(clock),
        .zera_s_n(zera_s_n),
        .conta(conta),
        .modo(modo),
        .inicia(inicia),
        .value(value),
        .dir(dir),
        .meio(meio),
        .fim(fim),
`ifdef CONTADOR_TRIANGULAR_CICLOS_EN
        .ciclos(ciclos),
`endif
        .ativo(ativo)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_tot  = 0;

    // Model: a phase index walks each mode's period; value is a
    // closed-form function of (mode, phase).
    int m_mode, m_ph, m_val, m_cic;
    bit m_dir, m_meio, m_fim, m_ativo;

    function automatic int plen(input int md);
        return (md == 1 || md == 2) ? MAX + 1 : 2 * MAX;
    endfunction

    function automatic int vof(input int md, input int ph);
        if (md == 1) return ph;
        if (md == 2) return MAX - ph;
        return (ph <= MAX) ? ph : 2 * MAX - ph;
    endfunction

    function automatic int ph0(input int md);
        return (md == 2) ? MAX : 0;
    endfunction

    task automatic model(input bit c, input int md, input bit ini,
                         input bit rst_n);
        m_meio = 0;
        m_fim  = 0;
        if (!rst_n) begin
            m_mode  = md;
            m_ph    = ph0(md);
            m_val   = 0;
            m_dir   = 1;
            m_ativo = (md != 3);
            m_cic   = 0;
        end else if (c) begin
            if (m_mode == 3 && !m_ativo) begin
                m_ativo = ini;
            end else begin
                m_ph  = (m_ph + 1) % plen(m_mode);
                m_val = vof(m_mode, m_ph);
                if (m_mode == 1) m_dir = 1;
                else if (m_mode == 2) m_dir = 0;
                else m_dir = (m_ph < MAX);
                m_meio = (m_val == MAX);
                m_fim  = (m_val == 0);
                if (m_fim) begin
                    if (m_cic < 255) m_cic++;
                    m_mode  = md;
                    m_ph    = ph0(md);
                    m_ativo = (md != 3);
                end
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step(input bit c, input int md, input bit ini,
                        input bit rst_n);
        int act, exp;
        zera_s_n = rst_n;
        conta    = c;
        modo     = 2'(md);
        inicia   = ini;
        @(posedge clock);
        model(c, md, ini, rst_n);
        #1;
        act = {value, dir, meio, fim, ativo};
        exp = {4'(m_val), m_dir, m_meio, m_fim, m_ativo};
        chk("model {value,dir,meio,fim,ativo}", act, exp);
`ifdef CONTADOR_TRIANGULAR_CICLOS_EN
        chk("model ciclos", int'(ciclos), m_cic);
`endif
    endtask

    int tri_v[15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int up_v[9]   = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

    initial begin
        int md;
        bit rn, cn, in;

        // Triangle literal sequence
        step(0, 0, 0, 0);
        chk("reset value", int'(value), 0);
        chk("reset dir", int'(dir), 1);
        chk("reset ativo", int'(ativo), 1);
        chk("reset fim/meio", int'({meio, fim}), 0);
        for (int i = 0; i < 15; i++) begin
            step(1, 0, 0, 1);
            chk("tri value", int'(value), tri_v[i]);
            chk("tri meio", int'(meio), int'(i == 6));
            chk("tri fim", int'(fim), int'(i == 13));
            chk("tri dir", int'(dir), int'(i < 6 || i >= 13));
        end

        // Sawtooth-up literal sequence
        step(0, 1, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(1, 1, 0, 1);
            chk("up value", int'(value), up_v[i]);
            chk("up fim", int'(fim), int'(i == 7));
            chk("up dir", int'(dir), 1);
        end

        // Single sweep
        step(0, 3, 0, 0);
        chk("sweep reset ativo", int'(ativo), 0);
        for (int i = 0; i < 5; i++) step(1, 3, 0, 1);
        chk("sweep idle value", int'(value), 0);
        chk("sweep idle ativo", int'(ativo), 0);
        step(1, 3, 1, 1);
        chk("sweep start ativo", int'(ativo), 1);
        chk("sweep start value", int'(value), 0);
        for (int i = 0; i < 14; i++) begin
            step(1, 3, i == 5, 1);
            chk("sweep value", int'(value), tri_v[i]);
            chk("sweep fim", int'(fim), int'(i == 13));
        end
        chk("sweep end ativo", int'(ativo), 0);
        for (int i = 0; i < 3; i++) step(1, 3, 0, 1);
        chk("sweep held value", int'(value), 0);

        // Mode change mid-period
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
        for (int i = 0; i < 11; i++) step(1, 1, 0, 1);
        chk("switch tri fim", int'({value, fim}), 1);
        for (int i = 0; i < 7; i++) step(1, 1, 0, 1);
        chk("switch up peak", int'(value), 7);
        step(1, 1, 0, 1);
        chk("switch up wrap", int'({value, fim}), 1);

        // conta toggling, then reset mid-period
        step(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(i % 2 == 0, 0, 0, 1);
        chk("toggle value", int'(value), 5);
        step(1, 0, 1, 0);
        chk("midreset value/dir", int'({value, dir}), 1);

        // Random traffic
        md = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(19) == 0) md = $urandom_range(3);
            rn = ($urandom_range(99) != 0);
            cn = ($urandom_range(3) != 0);
            in = ($urandom_range(7) == 0);
            step(cn, md, in, rn);
        end

`ifdef CONTADOR_TRIANGULAR_CICLOS_EN
        step(0, 0, 0, 0);
        chk("ciclos reset", int'(ciclos), 0);
        for (int i = 0; i < 14; i++) step(1, 0, 0, 1);
        chk("ciclos first", int'(ciclos), 1);
        for (int i = 0; i < 299 * 14; i++) step(1, 0, 0, 1);
        chk("ciclos saturate", int'(ciclos), 255);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
